x1_mbox_host2sub: RTL and testbench
===================================

# x1_mbox_host2sub

Host-to-sub-CPU mailbox for the X1 mr16 subsystem. The host side (Z80 I/O decode) pushes command bytes into a small FIFO. The block presents the head byte plus status as a 16-bit word on one mr16 GPIO input port, consumes the port's IN-ack strobe as a pop, and raises one mr16 interrupt line that is cleared by that line's ACK.

## Interface
Parameters:
- DEPTH_LOG2, 4 — FIFO depth is 2^DEPTH_LOG2 bytes; legal range 1..5.

Ports:
- I_CLK  in  1 — single clock; all logic on its rising edge.
- I_RESET  in  1 — synchronous, active-high reset.
- I_HOST_WE  in  1 — one-cycle host write strobe.
- I_HOST_A  in  1 — host register select: 0 = DATA, 1 = CTRL.
- I_HOST_D  in  8 — host write data.
- O_HOST_D  out  8 — host read data for the selected register; combinational from registers.
- O_PDATA  out  16 — word driven onto an mr16 GPIO input port.
- I_POP  in  1 — mr16 IN-ack strobe for that port; may stay high several cycles.
- O_INT  out  1 — interrupt request to one mr16 INT input; level.
- I_ACK  in  1 — mr16 ACK for that INT line.

## Operation
- O_PDATA bits:
  - [15] not-empty.
  - [14] overflow sticky.
  - [13:8] byte count, zero-extended.
  - [7:0] head byte, or 0 when empty.
- Host DATA write: pushes I_HOST_D[7:0].
  - If full and no pop accepted in the same cycle: byte dropped, overflow sticky set.
- Host CTRL write:
  - bit0 IEN, stored.
  - bit1 FLUSH, self-clearing: count, read pointer and write pointer go to 0.
  - bit2 CLROVF, self-clearing: clears the overflow sticky.
  - bit3 DOORBELL, self-clearing: sets the interrupt pending flag if IEN (new value) = 1.
- Host reads:
  - DATA reads {not-empty, overflow, full, IEN, count[3:0]}; count saturates at 15 in this 4-bit field.
  - CTRL reads {7'b0, irq_pend}.
- Pop:
  - Detect the rising edge of I_POP using a 1-bit registered previous value.
  - One edge means one pop, if the FIFO is non-empty; a pop while empty is ignored.
  - A multi-cycle I_POP high produces exactly one pop.
- Interrupt (irq_pend, driven on O_INT):
  - Set when a push is accepted into an empty FIFO with IEN=1, or on DOORBELL.
  - Cleared when I_ACK=1.
  - Set and clear in the same cycle: set wins.
  - Clearing IEN does not clear a pending request.
- Simultaneous events in one cycle:
  - Push and pop while full: both accepted, count unchanged, no overflow.
  - Push and pop while empty: push accepted, pop ignored; irq sets per the push rule.
  - FLUSH and DATA push cannot coincide (single-port host select).
  - FLUSH and pop: flush wins, FIFO ends empty.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. Count is DEPTH_LOG2+1 bits.

## Timing
- Reset: all storage pointers, count, IEN, overflow, irq_pend, and the I_POP history bit are 0. Hence O_PDATA=16'h0000, O_INT=0, O_HOST_D=8'h00.
- Push at edge N: O_PDATA reflects the new count and head from edge N onward, i.e. visible in cycle N+1.
- O_INT rises in the cycle after the accepting edge.
- Pop: I_POP rises in cycle M and is sampled at edge M+1. Head and count update at that same edge.
- The next word appears in cycle M+1, in time for the mr16 register stage before the following read.
- I_ACK sampled high at an edge: O_INT low from that edge on, unless set in the same cycle.
- No combinational path from any input to O_PDATA or O_INT.

## Structure
- Shared package x1_mbox_pkg holds:
  - Register offsets: DATA=0, CTRL=1.
  - CTRL bit indices: IEN=0, FLUSH=1, CLROVF=2, DOORBELL=3.
  - O_PDATA field positions: VALID=15, OVF=14, CNT_HI=13, CNT_LO=8.
- One sub-module, x1_mbox_fifo, is a synchronous byte FIFO.
  - Inputs: push, pop, flush.
  - Outputs: head, count, empty, full.
  - Storage is a register array; reads are combinational.
- The top level holds the edge detector, host register decode, overflow sticky and irq logic.

## Test plan
- Reset, then push 8'hA5 with IEN=1: O_PDATA=16'h81A5 next cycle; O_INT=1; I_ACK pulse → O_INT=0 next cycle.
- Push 3 bytes (11,22,33); hold I_POP high 4 cycles, then low, twice → exactly 2 pops; O_PDATA=16'h8133.
- Fill 16 bytes then push 8'hFF → O_PDATA[14]=1, count=16, head unchanged. Push and pop in the same cycle while full → count stays 16, no new overflow. Then CLROVF → bit14=0.
- IEN=0, push into empty → O_INT stays 0. Then DOORBELL with IEN=1 → O_INT=1. Then DOORBELL and I_ACK in the same cycle → O_INT stays 1.
- Pop edge on empty → no change. Push 8'h5A and pop edge in the same cycle on empty → count=1, head=8'h5A.
- Fill 5 bytes, assert I_RESET for one cycle during an I_POP high → all outputs 0, and no pop is registered after reset even though I_POP remains high.

Source files
------------

// File: rtl/x1_mbox_pkg.sv
// Shared constants for the X1 host-to-sub-CPU mailbox: host register map,
// CTRL bit positions and the layout of the word presented to the mr16 GPIO port.
package x1_mbox_pkg;

  typedef enum logic {
    REG_DATA = 1'b0,
    REG_CTRL = 1'b1
  } reg_sel_e;

  localparam int CTRL_IEN      = 0;
  localparam int CTRL_FLUSH    = 1;
  localparam int CTRL_CLROVF   = 2;
  localparam int CTRL_DOORBELL = 3;

  localparam int PD_VALID  = 15;
  localparam int PD_OVF    = 14;
  localparam int PD_CNT_HI = 13;
  localparam int PD_CNT_LO = 8;

  // Host status only has a 4-bit count field; a full 16-entry FIFO reads as 15.
  function automatic logic [3:0] sat_cnt4(input logic [5:0] cnt);
    return (cnt > 6'd15) ? 4'hF : cnt[3:0];
  endfunction

endpackage

// File: rtl/x1_mbox_fifo.sv
// Synchronous byte FIFO with combinational head read. Caller only asserts
// push/pop when they are legal (push when not full or popping, pop when not empty).
module x1_mbox_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  I_CLK,
  input  logic                  I_RESET,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [7:0]            wdata,
  output logic [7:0]            head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);

  logic [7:0]            mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2-1:0] wptr;

  // NOTE: the storage array has no reset; the pointers and count alone define
  // which entries are valid, so stale data is never observable.
  always_ff @(posedge I_CLK) begin
    if (push && !flush) mem[wptr] <= wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge I_CLK) begin
    if (I_RESET || flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rptr];
  assign empty = (count == '0);
  assign full  = count[DEPTH_LOG2];

endmodule

// File: rtl/x1_mbox_host2sub.sv
// Host-to-sub-CPU mailbox: host pushes bytes, mr16 reads head+status on a GPIO
// port and pops on the IN-ack rising edge; one level interrupt with ACK clear.
module x1_mbox_host2sub
  import x1_mbox_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_HOST_WE,
  input  logic        I_HOST_A,
  input  logic [7:0]  I_HOST_D,
  output logic [7:0]  O_HOST_D,
  output logic [15:0] O_PDATA,
  input  logic        I_POP,
  output logic        O_INT,
  input  logic        I_ACK
);

  logic                pop_q;
  logic                ien;
  logic                ovf;
  logic                irq_pend;

  logic [7:0]          fifo_head;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                fifo_empty;
  logic                fifo_full;

  logic                data_we;
  logic                ctrl_we;
  logic                flush;
  logic                pop_edge;
  logic                pop_acc;
  logic                push_acc;
  logic                ovf_set;
  logic                irq_set;
  logic [5:0]          cnt6;

  assign data_we  = I_HOST_WE && (reg_sel_e'(I_HOST_A) == REG_DATA);
  assign ctrl_we  = I_HOST_WE && (reg_sel_e'(I_HOST_A) == REG_CTRL);
  assign flush    = ctrl_we && I_HOST_D[CTRL_FLUSH];

  // A pop frees the slot the push writes into, so a full FIFO still accepts.
  assign pop_edge = I_POP && !pop_q;
  assign pop_acc  = pop_edge && !fifo_empty && !flush;
  assign push_acc = data_we && (!fifo_full || pop_acc);
  assign ovf_set  = data_we && fifo_full && !pop_acc;
  assign irq_set  = (push_acc && fifo_empty && ien) ||
                    (ctrl_we && I_HOST_D[CTRL_DOORBELL] && I_HOST_D[CTRL_IEN]);

  x1_mbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .I_CLK   (I_CLK),
    .I_RESET (I_RESET),
    .push    (push_acc),
    .pop     (pop_acc),
    .flush   (flush),
    .wdata   (I_HOST_D),
    .head    (fifo_head),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      pop_q    <= 1'b0;
      ien      <= 1'b0;
      ovf      <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      pop_q <= I_POP;
      if (ctrl_we) ien <= I_HOST_D[CTRL_IEN];
      if (ovf_set) ovf <= 1'b1;
      else if (ctrl_we && I_HOST_D[CTRL_CLROVF]) ovf <= 1'b0;
      if (irq_set)    irq_pend <= 1'b1;
      else if (I_ACK) irq_pend <= 1'b0;
    end
  end

  assign cnt6 = 6'(fifo_count);

  always_comb begin
    O_PDATA                      = '0;
    O_PDATA[PD_VALID]            = !fifo_empty;
    O_PDATA[PD_OVF]              = ovf;
    O_PDATA[PD_CNT_HI:PD_CNT_LO] = cnt6;
    O_PDATA[7:0]                 = fifo_empty ? 8'h00 : fifo_head;
  end

  assign O_INT    = irq_pend;
  assign O_HOST_D = (reg_sel_e'(I_HOST_A) == REG_DATA)
                  ? {!fifo_empty, ovf, fifo_full, ien, sat_cnt4(cnt6)}
                  : {7'b0, irq_pend};

endmodule

// File: tb/tb_x1_mbox_host2sub.sv
// Self-checking bench for x1_mbox_host2sub: behavioural queue model feeds a
// scoreboard of expected outputs, plus directed checks of the key scenarios.
module tb_x1_mbox_host2sub;

  logic        I_CLK = 1'b0;
  logic        I_RESET;
  logic        I_HOST_WE;
  logic        I_HOST_A;
  logic [7:0]  I_HOST_D;
  logic [7:0]  O_HOST_D;
  logic [15:0] O_PDATA;
  logic        I_POP;
  logic        O_INT;
  logic        I_ACK;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] pdata;
    logic        intr;
    logic [7:0]  hostd;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mq[$];
  logic        m_ovf, m_ien, m_irq, m_prev;

  x1_mbox_host2sub #(.DEPTH_LOG2(4)) dut (
    .I_CLK     (I_CLK),
    .I_RESET   (I_RESET),
    .I_HOST_WE (I_HOST_WE),
    .I_HOST_A  (I_HOST_A),
    .I_HOST_D  (I_HOST_D),
    .O_HOST_D  (O_HOST_D),
    .O_PDATA   (O_PDATA),
    .I_POP     (I_POP),
    .O_INT     (O_INT),
    .I_ACK     (I_ACK)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour at one clock edge, applied to the queue model.
  task automatic model_edge(input logic we, input logic a, input logic [7:0] d,
                            input logic pop, input logic ack, input logic rst);
    logic edge_seen, flush, popd, was_empty, was_full, irq_n;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_ien = 0; m_irq = 0; m_prev = 0;
      return;
    end
    edge_seen = pop && !m_prev;
    m_prev    = pop;
    flush     = we && a && d[1];
    was_empty = (mq.size() == 0);
    was_full  = (mq.size() == 16);
    popd      = edge_seen && !was_empty && !flush;
    irq_n     = ack ? 1'b0 : m_irq;
    if (popd) void'(mq.pop_front());
    if (we && !a) begin
      if (!was_full || popd) begin
        mq.push_back(d);
        if (was_empty && m_ien) irq_n = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (we && a) begin
      m_ien = d[0];
      if (d[1]) mq.delete();
      if (d[2]) m_ovf = 1'b0;
      if (d[3] && d[0]) irq_n = 1'b1;
    end
    m_irq = irq_n;
  endtask

  function automatic exp_t model_out(input logic a);
    exp_t e;
    int   n;
    logic [3:0] c4;
    n  = mq.size();
    c4 = (n > 15) ? 4'hF : 4'(n);
    e.pdata = {n != 0, m_ovf, 6'(n), (n != 0) ? mq[0] : 8'h00};
    e.intr  = m_irq;
    e.hostd = a ? {7'b0, m_irq} : {n != 0, m_ovf, n == 16, m_ien, c4};
    return e;
  endfunction

  // Drive one cycle of inputs, score outputs 1 time unit after the edge.
  task automatic step(input logic we, input logic a, input logic [7:0] d,
                      input logic pop, input logic ack, input logic rst = 1'b0);
    exp_t e;
    I_HOST_WE = we; I_HOST_A = a; I_HOST_D = d;
    I_POP = pop; I_ACK = ack; I_RESET = rst;
    @(posedge I_CLK);
    model_edge(we, a, d, pop, ack, rst);
    sb.push_back(model_out(a));
    #1;
    e = sb.pop_front();
    check("pdata", O_PDATA, e.pdata);
    check("int",   16'(O_INT), 16'(e.intr));
    check("hostd", 16'(O_HOST_D), 16'(e.hostd));
  endtask

  task automatic idle(input logic pop = 1'b0);
    step(1'b0, 1'b0, 8'h00, pop, 1'b0);
  endtask

  task automatic push(input logic [7:0] d, input logic pop = 1'b0);
    step(1'b1, 1'b0, d, pop, 1'b0);
  endtask

  task automatic ctrl(input logic [7:0] d, input logic ack = 1'b0);
    step(1'b1, 1'b1, d, 1'b0, ack);
  endtask

  initial begin
    logic we, a, pp, ak;
    logic [7:0] d;

    #2;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("rst_pdata", O_PDATA, 16'h0000);
    check("rst_int",   16'(O_INT), 16'h0000);
    check("rst_hostd", 16'(O_HOST_D), 16'h0000);

    // Push into empty with IEN set, then acknowledge.
    ctrl(8'h01);
    push(8'hA5);
    check("a5_pdata", O_PDATA, 16'h81A5);
    check("a5_int",   16'(O_INT), 16'h0001);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("ack_int",  16'(O_INT), 16'h0000);

    // Long I_POP highs produce one pop each.
    ctrl(8'h03);
    push(8'h11); push(8'h22); push(8'h33);
    repeat (2) begin
      repeat (4) idle(1'b1);
      idle(1'b0);
    end
    check("pop2_pdata", O_PDATA, 16'h8133);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Fill, overflow, clear, then push+pop while full.
    ctrl(8'h03);
    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'hFF);
    check("ovf_pdata", O_PDATA, 16'hD000);
    idle();
    check("full_hostd", 16'(O_HOST_D), 16'h00FF);
    ctrl(8'h05);
    check("clrovf_pdata", O_PDATA, 16'h9000);
    push(8'hEE, 1'b1);
    check("pushpop_full", O_PDATA, 16'h9001);
    idle();

    // IEN=0 push does not interrupt; doorbell does, and beats a same-cycle ACK.
    ctrl(8'h02, 1'b1);
    push(8'h42);
    check("noien_int", 16'(O_INT), 16'h0000);
    ctrl(8'h09);
    check("bell_int", 16'(O_INT), 16'h0001);
    ctrl(8'h09, 1'b1);
    check("bell_ack_int", 16'(O_INT), 16'h0001);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check("ctrl_rd", 16'(O_HOST_D), 16'h0001);

    // Pop on empty is ignored; push+pop on empty keeps the push.
    ctrl(8'h02, 1'b1);
    idle(1'b1);
    check("pop_empty", O_PDATA, 16'h0000);
    idle(1'b0);
    push(8'h5A, 1'b1);
    check("pushpop_empty", O_PDATA, 16'h815A);
    idle();

    // Reset during a held I_POP.
    ctrl(8'h02);
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    idle(1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("rst2_pdata", O_PDATA, 16'h0000);
    check("rst2_int",   16'(O_INT), 16'h0000);
    idle(1'b1);
    push(8'h77, 1'b1);
    idle(1'b1);
    check("rst2_push", O_PDATA, 16'h8177);
    idle();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      we = ($urandom_range(0, 2) != 0);
      a  = ($urandom_range(0, 7) == 0);
      d  = 8'($urandom);
      if (a && $urandom_range(0, 3) != 0) d[1] = 1'b0;
      pp = ($urandom_range(0, 2) == 0);
      ak = ($urandom_range(0, 4) == 0);
      step(we, a, d, pp, ak);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
